// File: rtl/prpg_burst_ctrl.sv
// Burst controller that pulls patterns from an LFSR on demand, delivers BURST_LEN
// of them over valid/ready and compacts every accepted pattern into a MISR.
module prpg_burst_ctrl #(
    parameter int               WIDTH     = 8,
    parameter int               BURST_LEN = 16,
    parameter logic [WIDTH-1:0] POLY      = 8'hB8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [WIDTH-1:0]                   pat_in,
    output logic                               lfsr_en,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(BURST_LEN+1)-1:0]     count,
    output logic [WIDTH-1:0]                   signature
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_IDX  = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   issued_reg;
    logic            load;
    logic            accept;
    logic            misr_fb;
    logic [WIDTH-1:0] misr_next;

    // A new pattern may enter the output register when it is empty or being drained.
    assign load    = (state_reg == RUN) && (issued_reg < BURST_MAX) && (!out_valid || out_ready);
    assign accept  = out_valid && out_ready;
    assign lfsr_en = load;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

    // MISR: shift left, feed the tap parity into bit 0, then fold in the accepted word.
    assign misr_fb = ^(signature & POLY);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_misr
            if (gi == 0) begin : g_lsb
                assign misr_next[gi] = misr_fb ^ out_data[gi];
            end else begin : g_upper
                assign misr_next[gi] = signature[gi-1] ^ out_data[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            issued_reg <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            count      <= '0;
            signature  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= RUN;
                        issued_reg <= '0;
                        count      <= '0;
                        signature  <= '0;
                    end
                end

                RUN: begin
                    if (load) begin
                        out_data   <= pat_in;
                        out_valid  <= 1'b1;
                        issued_reg <= issued_reg + CW'(1);
                    end else if (accept) begin
                        out_valid  <= 1'b0;
                    end

                    if (accept) begin
                        count     <= count + CW'(1);
                        signature <= misr_next;
                        if (count == LAST_IDX) begin
                            state_reg <= DONE;
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prpg_burst_ctrl.sv
// Randomized and directed bench for prpg_burst_ctrl, scored against a
// transaction-level model of the burst, the pattern stream and the MISR.
module tb_prpg_burst_ctrl;

    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 16;
    localparam int CW        = $clog2(BURST_LEN + 1);
    localparam logic [WIDTH-1:0] POLY = 8'hB8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pat_in;
    logic             lfsr_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] signature;

    logic [WIDTH-1:0] lfsr;
    logic             hold_pat;

    int errors = 0;
    int checks = 0;

    prpg_burst_ctrl #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .POLY      (POLY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_in    (pat_in),
        .lfsr_en   (lfsr_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .signature (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // Upstream pattern source: Galois LFSR advanced whenever the controller asks.
    always @(posedge clk) begin
        if (!reset)       lfsr <= 8'h5A;
        else if (lfsr_en) lfsr <= lfsr_step(lfsr);
    end
    assign pat_in = hold_pat ? 8'h01 : lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_pattern(input logic [WIDTH-1:0] seed, input int idx,
                                                     input logic held);
        logic [WIDTH-1:0] x;
        if (held) return 8'h01;
        x = seed;
        for (int i = 0; i < idx; i++) x = lfsr_step(x);
        return x;
    endfunction

    function automatic logic [WIDTH-1:0] misr_fold(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] shifted;
        shifted = (s << 1) | {{(WIDTH-1){1'b0}}, ^(s & POLY)};
        return shifted ^ d;
    endfunction

    // Transaction-level model: phase 0=idle, 1=bursting, 2=finished.
    int               m_phase = 0;
    int               m_count = 0;
    logic [WIDTH-1:0] m_sig   = '0;
    logic [WIDTH-1:0] m_seed  = '0;
    logic             m_hold  = 1'b0;
    int               m_en    = 0;

    always @(negedge clk) begin
        if (!reset) begin
            m_phase = 0;
            m_count = 0;
            m_sig   = '0;
        end else begin
            check("busy", busy, (m_phase != 0));
            check("done", done, (m_phase == 2));
            check("count", count, m_count);
            check("signature", signature, m_sig);
            if (m_phase != 1) check("idle_valid", out_valid, 0);
            if (out_valid && !out_ready) check("stall_lfsr_en", lfsr_en, 0);
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_count = 0;
                    m_sig   = '0;
                    m_en    = 0;
                    m_seed  = pat_in;
                    m_hold  = hold_pat;
                end
                1: begin
                    if (lfsr_en) m_en++;
                    if (out_valid && out_ready) begin
                        check("out_data", out_data, exp_pattern(m_seed, m_count, m_hold));
                        m_sig = misr_fold(m_sig, exp_pattern(m_seed, m_count, m_hold));
                        m_count++;
                        $display("txn %0d data=%02h sig=%02h t=%0t", m_count, out_data, m_sig, $time);
                        if (m_count == BURST_LEN) begin
                            m_phase = 2;
                            check("lfsr_en_total", m_en, BURST_LEN);
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic start_burst();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int vcnt;
        logic [WIDTH-1:0] held_data;

        reset = 1'b0; start = 1'b0; out_ready = 1'b0; hold_pat = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Full-rate burst
        out_ready = 1'b1;
        start_burst();
        @(negedge clk);
        check("first_valid_lat", out_valid, 0);
        check("first_lfsr_en", lfsr_en, 1);
        vcnt = 0;
        for (int i = 0; i < BURST_LEN; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("valid_run", vcnt, BURST_LEN);
        @(negedge clk);
        check("end_valid", out_valid, 0);
        check("end_done", done, 1);
        check("end_count", count, BURST_LEN);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);

        // Signature with constant 8'h01 input
        hold_pat = 1'b1;
        start_burst();
        @(negedge clk);
        @(negedge clk);
        check("sig_before", signature, 8'h00);
        @(negedge clk);
        check("sig_first", signature, 8'h01);
        @(negedge clk);
        check("sig_second", signature, 8'h03);
        check("sig_count", count, 2);
        wait_done(100);
        hold_pat = 1'b0;

        // Backpressure: stall 3 cycles mid-burst
        start_burst();
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held_data = out_data;
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_lfsr_en", lfsr_en, 0);
            check("bp_data_hold", out_data, held_data);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(100);

        // Asynchronous reset after 5 accepts
        start_burst();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (count == 5) break;
        end
        check("pre_reset_count", count, 5);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_lfsr_en", lfsr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_signature", signature, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        start_burst();
        wait_done(100);
        check("post_reset_count", count, BURST_LEN);

        // Start pulses during RUN and DONE are ignored; start right after DONE restarts
        start_burst();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("restart_busy", busy, 1);
        check("restart_count", count, 0);
        wait_done(100);

        // Randomized backpressure and stray start pulses
        for (int b = 0; b < 5; b++) begin
            start_burst();
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                if (done) break;
            end
            check("rand_done", done, 1);
            @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prpg_burst_ctrl.md
# prpg_burst_ctrl

Downstream consumer of the LFSR pattern generator. It advances the LFSR on demand, captures each pseudo-random pattern, and delivers a fixed-length burst of patterns over a valid/ready handshake. It also compacts every accepted pattern into a multiple-input signature register (MISR), so a burst can be checked against a golden signature.

## Interface
- WIDTH, 8, pattern, MISR and output data width.
- BURST_LEN, 16, number of patterns per burst (≥1).
- POLY, 8'hB8, MISR feedback tap mask (WIDTH bits).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- pat_in  input  WIDTH  current LFSR state (pattern source).
- lfsr_en  output  1  combinational; advance LFSR this cycle (pattern on pat_in is consumed).
- out_data  output  WIDTH  registered pattern to the sink.
- out_valid  output  1  out_data holds an undelivered pattern.
- out_ready  input  1  sink accepts out_data this cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the last pattern is accepted.
- count  output  $clog2(BURST_LEN+1)  patterns accepted in current/last burst.
- signature  output  WIDTH  MISR value over accepted patterns.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. On that edge, clear count, signature, and the internal issued counter.
  - RUN → DONE on the edge where the BURST_LEN-th pattern is accepted.
  - DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE.
- issued counter: patterns loaded into the output register, 0..BURST_LEN.
- Load condition: `load = (state==RUN) && (issued<BURST_LEN) && (!out_valid || out_ready)`.
- lfsr_en = load (combinational).
- On a load edge: out_data ← pat_in, out_valid ← 1, issued++.
- Accept: out_valid && out_ready.
  - On an accept edge without a load, out_valid ← 0.
  - Load and accept in the same cycle keep out_valid = 1 (full throughput).
- On every accept:
  - count++
  - signature ← ((signature<<1) | ^(signature & POLY)) ^ out_data, truncated to WIDTH.
- While out_valid && !out_ready: out_data and out_valid hold, lfsr_en = 0.
- count and signature hold after DONE until the next start.
- busy = (state != IDLE). done = (state == DONE).
- Reset (reset=0, asynchronous, any state): state IDLE, issued = 0, and all registered outputs 0 (out_data, out_valid, count, signature). lfsr_en, busy, and done are therefore 0. A burst in progress is abandoned.

## Timing
- Start taken at edge k. The first load is at edge k+1, so out_valid is high after k+1.
- Throughput: with out_ready held high, one pattern per cycle. out_valid is high for exactly BURST_LEN consecutive cycles.
- Latency: pat_in sampled at edge t appears on out_data after t.
- Last accept at edge m: state DONE after m, done=1 for the cycle m..m+1, IDLE after m+1.
  - count = BURST_LEN and the final signature are visible after m.
- Earliest next start is sampled at edge m+2. Back-to-back bursts have one idle cycle between DONE and the new RUN.
- lfsr_en pulses total exactly BURST_LEN per completed burst, regardless of backpressure.

## Test plan
- Reset values: assert reset=0 mid-simulation → out_data=0, out_valid=0, lfsr_en=0, busy=0, done=0, count=0, signature=0 immediately, before any clk edge.
- Full-rate burst: BURST_LEN=16, out_ready=1, start pulse → 16 consecutive out_valid cycles and 16 lfsr_en cycles. out_data sequence equals the LFSR states. done pulses once, count=16, busy falls one cycle after done.
- Signature check: WIDTH=8, POLY=8'hB8, BURST_LEN=2, pat_in held at 8'h01, out_ready=1 → signature=8'h01 after the first accept and 8'h03 after the second, count=2.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → out_data stable, lfsr_en=0 for those cycles. Delivery resumes when out_ready returns, no pattern is lost or duplicated, and the total lfsr_en count is still BURST_LEN.
- Reset mid-burst: reset=0 after 5 accepts, then release and start again → the second burst delivers BURST_LEN patterns with count restarting from 0 and a signature computed from 0.
- Ignored start: pulse start during RUN and during DONE → no restart, count and issued unaffected. A start one cycle after DONE begins a new burst.
